// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed LUT neuron layer: one shared truth-table RAM evaluates NUM_NEURONS neurons per vector.
// Optional feature: define LUT_SCHED_PARITY_EN to store and check an even-parity bit per truth entry.
//
// state | meaning
// IDLE  | accept config writes and the next input vector
// EVAL  | issue one truth-table read per neuron, plus one drain cycle
// DONE  | hold the assembled result until out_ready
module lut_layer_scheduler #(
  parameter  int NUM_NEURONS = 8,
  parameter  int IN_FEATURES = 16,
  parameter  int FAN_IN      = 4,
  parameter  int IN_BITS     = 2,
  parameter  int OUT_BITS    = 2,
  localparam int AW          = FAN_IN * IN_BITS,
  localparam int DEPTH       = NUM_NEURONS << AW,
  localparam int ADDRW       = $clog2(DEPTH),
  localparam int CW          = $clog2(IN_FEATURES),
  localparam int DW          = (OUT_BITS > CW) ? OUT_BITS : CW
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_FEATURES*IN_BITS-1:0]  in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                            cfg_we,
  input  logic                            cfg_sel,
  input  logic [ADDRW-1:0]                cfg_addr,
  input  logic [DW-1:0]                   cfg_wdata,
  output logic                            cfg_ready,
  output logic                            err
);

  localparam int NW      = $clog2(NUM_NEURONS);
  localparam int CNTW    = $clog2(NUM_NEURONS + 1);
  localparam int FIW     = $clog2(FAN_IN);
  localparam int CONN_AW = $clog2(NUM_NEURONS * FAN_IN);
`ifdef LUT_SCHED_PARITY_EN
  localparam int TW = OUT_BITS + 1;
`else
  localparam int TW = OUT_BITS;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, DONE = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [CNTW-1:0]     cnt;
  logic [NW-1:0]       nidx;
  logic [IN_BITS-1:0]  feat_q   [IN_FEATURES];
  logic [CW-1:0]       conn_mem [NUM_NEURONS][FAN_IN];
  logic [TW-1:0]       tt_mem   [DEPTH];
  logic [TW-1:0]       tt_wr;
  logic [TW-1:0]       rd_data;
  logic                rd_vld;
  logic [NW-1:0]       rd_idx;
  logic [OUT_BITS-1:0] slot_q   [NUM_NEURONS];
  logic [AW-1:0]       lut_addr;
  logic [ADDRW-1:0]    raddr;
  logic                accept, issue, tt_we, conn_we;

  assign nidx    = cnt[NW-1:0];
  assign accept  = (state == IDLE) && in_valid;
  assign issue   = (state == EVAL) && (cnt < CNTW'(NUM_NEURONS));
  assign tt_we   = cfg_we && (state == IDLE) && !cfg_sel;
  assign conn_we = cfg_we && (state == IDLE) && cfg_sel && (cfg_addr < ADDRW'(NUM_NEURONS * FAN_IN));
  assign raddr   = {nidx, lut_addr};

`ifdef LUT_SCHED_PARITY_EN
  assign tt_wr = {^cfg_wdata[OUT_BITS-1:0], cfg_wdata[OUT_BITS-1:0]};
`else
  assign tt_wr = cfg_wdata[OUT_BITS-1:0];
`endif

  // Out-of-range feature indices can only exist when IN_FEATURES is not a power of two.
  if (IN_FEATURES == (1 << CW)) begin : g_gather_full
    always_comb begin
      lut_addr = '0;
      for (int i = 0; i < FAN_IN; i++)
        lut_addr[i*IN_BITS +: IN_BITS] = feat_q[conn_mem[nidx][i]];
    end
  end else begin : g_gather_part
    always_comb begin
      lut_addr = '0;
      for (int i = 0; i < FAN_IN; i++)
        lut_addr[i*IN_BITS +: IN_BITS] = (conn_mem[nidx][i] < CW'(IN_FEATURES)) ?
                                         feat_q[conn_mem[nidx][i]] : '0;
    end
  end

  // Table storage is deliberately not reset so configuration survives rst.
  always_ff @(posedge clk) begin
    if (tt_we) tt_mem[cfg_addr] <= tt_wr;
    if (issue) rd_data <= tt_mem[raddr];
    if (conn_we) conn_mem[cfg_addr[CONN_AW-1:FIW]][cfg_addr[FIW-1:0]] <= cfg_wdata[CW-1:0];
    if (accept)
      for (int f = 0; f < IN_FEATURES; f++) feat_q[f] <= in_data[f*IN_BITS +: IN_BITS];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EVAL;
      EVAL:    if (cnt == CNTW'(NUM_NEURONS)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    cfg_ready = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      rd_vld <= 1'b0;
      rd_idx <= '0;
      for (int n = 0; n < NUM_NEURONS; n++) slot_q[n] <= '0;
    end else begin
      rd_vld <= issue;
      if (issue) rd_idx <= nidx;
      if (accept) begin
        cnt <= '0;
        for (int n = 0; n < NUM_NEURONS; n++) slot_q[n] <= '0;
      end else if (state == EVAL) begin
        cnt <= cnt + 1'b1;
        if (rd_vld) slot_q[rd_idx] <= rd_data[OUT_BITS-1:0];
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int n = 0; n < NUM_NEURONS; n++) out_data[n*OUT_BITS +: OUT_BITS] = slot_q[n];
  end

`ifdef LUT_SCHED_PARITY_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)                                        err_q <= 1'b0;
    else if ((state == EVAL) && rd_vld && ^rd_data) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Directed self-checking bench for lut_layer_scheduler (default parameters).
module tb_lut_layer_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data;
  logic [15:0] out_data;
  logic        cfg_we, cfg_sel, cfg_ready, err;
  logic [10:0] cfg_addr;
  logic [3:0]  cfg_wdata;

  int checks   = 0;
  int failures = 0;

  // Vector A: features 0..3 = 3,2,1,0. Vector B adds features 4..7 = 1,3,0,2.
  localparam logic [31:0] VEC_A = 32'h0000_001B;
  localparam logic [31:0] VEC_B = 32'h0000_8D1B;

  always #5 clk = ~clk;

  lut_layer_scheduler dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_ready(cfg_ready), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input logic [10:0] addr, input logic [3:0] data);
    cfg_sel   = sel;
    cfg_addr  = addr;
    cfg_wdata = data;
    cfg_we    = 1'b1;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic start_vec(input string tag, input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_cleared"}, {16'h0, out_data}, 32'h0);
  endtask

  // n0 = cycles already elapsed, counting the accept cycle as 1
  task automatic wait_result(input string tag, input int n0, input logic [15:0] exp);
    int n = n0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 10);
    check({tag, "_data"}, {16'h0, out_data}, {16'h0, exp});
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    check({tag, "_out_valid"}, {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;

    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready",  {31'h0, in_ready},  32'h1);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data",  {16'h0, out_data},  32'h0);
    check("rst_err",       {31'h0, err},       32'h0);
    check("rst_cfg_ready", {31'h0, cfg_ready}, 32'h1);

    // Connectivity: neuron 0 -> features 0..3, neuron 5 -> features 4..7, others -> feature 0.
    for (int n = 0; n < 8; n++)
      for (int i = 0; i < 4; i++)
        cfg_write(1'b1, 11'(n * 4 + i), (n == 0) ? 4'(i) : (n == 5) ? 4'(4 + i) : 4'd0);
    cfg_write(1'b0, {3'd0, 8'h1B}, 4'd2);
    for (int n = 1; n < 8; n++) cfg_write(1'b0, {3'(n), 8'hFF}, 4'd0);
    cfg_write(1'b0, {3'd5, 8'h00}, 4'd0);
    cfg_write(1'b0, {3'd5, 8'h8D}, 4'd3);

    start_vec("a1", VEC_A);
    wait_result("a1", 1, 16'h0002);
    handshake("a1");

    start_vec("b1", VEC_B);
    wait_result("b1", 1, 16'h0C02);
    handshake("b1");

    // Result held under backpressure; in_valid during DONE is ignored.
    start_vec("hold", VEC_A);
    wait_result("hold", 1, 16'h0002);
    in_data  = VEC_B;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_data",      {16'h0, out_data},  32'h0002);
      check("hold_in_ready",  {31'h0, in_ready},  32'h0);
      check("hold_out_valid", {31'h0, out_valid}, 32'h1);
    end
    in_valid = 1'b0;
    handshake("hold");

    // Config write during EVAL is dropped.
    start_vec("drop", VEC_A);
    cfg_sel = 1'b0; cfg_addr = {3'd0, 8'h1B}; cfg_wdata = 4'd1; cfg_we = 1'b1;
    check("drop_cfg_ready", {31'h0, cfg_ready}, 32'h0);
    tick();
    cfg_we = 1'b0;
    wait_result("drop", 2, 16'h0002);
    handshake("drop");
    start_vec("drop2", VEC_A);
    wait_result("drop2", 1, 16'h0002);
    handshake("drop2");

    // Simultaneous config write and vector accept: the new entry is used.
    cfg_sel = 1'b0; cfg_addr = {3'd5, 8'h8D}; cfg_wdata = 4'd1; cfg_we = 1'b1;
    in_data = VEC_B; in_valid = 1'b1;
    tick();
    cfg_we = 1'b0; in_valid = 1'b0;
    wait_result("simul", 1, 16'h0402);
    handshake("simul");
    cfg_write(1'b0, {3'd5, 8'h8D}, 4'd3);
    start_vec("b2", VEC_B);
    wait_result("b2", 1, 16'h0C02);
    handshake("b2");

    // Reset in EVAL cycle 4 aborts and clears partial results.
    start_vec("abort", VEC_A);
    repeat (4) tick();
    check("abort_partial", {16'h0, out_data}, 32'h0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready",  {31'h0, in_ready},  32'h1);
    check("abort_out_data",  {16'h0, out_data},  32'h0);
    check("abort_out_valid", {31'h0, out_valid}, 32'h0);
    check("abort_cfg_ready", {31'h0, cfg_ready}, 32'h1);
    repeat (12) tick();
    check("abort_no_valid", {31'h0, out_valid}, 32'h0);
    start_vec("a3", VEC_A);
    wait_result("a3", 1, 16'h0002);
    handshake("a3");
    check("err_clean", {31'h0, err}, 32'h0);

`ifdef LUT_SCHED_PARITY_EN
    dut.tt_mem[11'h01B] = dut.tt_mem[11'h01B] ^ 3'b100;
    start_vec("par", VEC_A);
    wait_result("par", 1, 16'h0002);
    check("par_err", {31'h0, err}, 32'h1);
    handshake("par");
    repeat (3) tick();
    check("par_err_sticky", {31'h0, err}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("par_err_cleared", {31'h0, err}, 32'h0);
    dut.tt_mem[11'h01B] = dut.tt_mem[11'h01B] ^ 3'b100;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
